// File: rtl/ram_banked.sv
// ram_banked: single-port RAM split into 2^BANK_BITS banks, with a
// self-clearing fill sequence after reset or on a clear request.
// Reads are registered (one cycle latency) and flagged by dados_valid.

module ram_banked #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int BANK_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              write_enable,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dados_in,
    output logic [DATA_W-1:0] dados_out,
    output logic              dados_valid,
    output logic              busy
);

    localparam int NUM_BANKS  = 1 << BANK_BITS;
    localparam int OFF_W      = ADDR_W - BANK_BITS;
    localparam int BANK_DEPTH = 1 << OFF_W;

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] fill_cnt;

    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_we;
    logic [OFF_W-1:0]  acc_off;
    logic [DATA_W-1:0] read_word;

    // The fill sequence and user requests share one access port; during
    // FILL the counter owns it and writes zero, otherwise the user does.
    always_comb begin
        acc_addr = addr;
        acc_data = dados_in;
        acc_we   = 1'b0;
        if (!rst) begin
            if (state == FILL) begin
                acc_addr = fill_cnt;
                acc_data = '0;
                acc_we   = 1'b1;
            end else begin
                acc_we = enable & write_enable & ~clear;
            end
        end
    end

    assign acc_off = acc_addr[OFF_W-1:0];
    assign busy    = (state == FILL);

    generate
        if (BANK_BITS > 0) begin : g_banks
            logic [BANK_BITS-1:0] acc_bank;
            logic [DATA_W-1:0]    bank_rd [NUM_BANKS];

            assign acc_bank = acc_addr[ADDR_W-1 -: BANK_BITS];

            for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
                logic [DATA_W-1:0] bank_mem [BANK_DEPTH];

                // Each bank only accepts writes whose upper address bits select it
                always_ff @(posedge clk) begin
                    if (acc_we && (acc_bank == BANK_BITS'(b))) begin
                        bank_mem[acc_off] <= acc_data;
                    end
                end

                assign bank_rd[b] = bank_mem[acc_off];
            end

            assign read_word = bank_rd[acc_bank];
        end else begin : g_flat
            logic [DATA_W-1:0] flat_mem [BANK_DEPTH];

            // Single flat memory when no bank bits are configured
            always_ff @(posedge clk) begin
                if (acc_we) begin
                    flat_mem[acc_off] <= acc_data;
                end
            end

            assign read_word = flat_mem[acc_off];
        end
    endgenerate

    // FSM, fill counter and registered read output
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            fill_cnt    <= '0;
            dados_out   <= '0;
            dados_valid <= 1'b0;
        end else begin
            dados_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (clear) begin
                        fill_cnt <= '0;
                    end else if (fill_cnt == '1) begin
                        fill_cnt <= '0;
                        state    <= READY;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: begin
                    if (clear) begin
                        state    <= FILL;
                        fill_cnt <= '0;
                    end else if (enable && !write_enable) begin
                        dados_out   <= read_word;
                        dados_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ram_banked.md
RAM_BANKED -- requirements
Module: ram_banked

Interface
REQ-001 Parameter DATA_W, default 8, shall set the word width in bits.
REQ-002 Parameter ADDR_W, default 3, shall set the address width, giving a depth of 2^ADDR_W words.
REQ-003 Parameter BANK_BITS, default 1, shall set the number of banks to 2^BANK_BITS.
  - Legal range: 0 <= BANK_BITS < ADDR_W.
  - Bank index = addr[ADDR_W-1 -: BANK_BITS].
REQ-004 clk  input  1  shall be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  shall be the synchronous, active-high reset.
REQ-006 enable  input  1  shall qualify a request in the current cycle.
REQ-007 write_enable  input  1  shall select the access type when enable=1: 1 = write, 0 = read.
REQ-008 clear  input  1  shall request a full zero-fill of the memory when sampled high.
REQ-009 addr  input  ADDR_W  shall carry the word address.
REQ-010 dados_in  input  DATA_W  shall carry the write data.
REQ-011 dados_out  output  DATA_W  shall carry the registered read data.
REQ-012 dados_valid  output  1  shall pulse high for one cycle when dados_out carries new read data.
REQ-013 busy  output  1  shall be high while the block is filling and ignoring requests.

Function
REQ-014 The block shall use a two-state FSM: FILL and READY.
REQ-015 In FILL, a fill counter shall start at 0 and write 0 to one word per cycle, then increment.
REQ-016 After the cycle that writes word 2^ADDR_W-1, the FSM shall enter READY.
  - Fill duration is exactly 2^ADDR_W cycles.
REQ-017 busy shall be 1 in every FILL cycle and 0 in READY.
REQ-018 In FILL, enable and write_enable shall be ignored: no writes and no dados_valid pulse.
REQ-019 In READY, clear=1 shall enter FILL on the next edge with the counter reset to 0. Any request sampled in that same cycle shall be ignored.
REQ-020 clear=1 during FILL shall restart the counter at 0.
REQ-021 In READY, enable=1 with write_enable=1 shall store dados_in at addr on that edge. The write shall go to the selected bank only; other banks are unchanged.
REQ-022 In READY, enable=1 with write_enable=0 shall produce a read with 1-cycle latency:
  - dados_out is loaded with mem[addr] on the edge.
  - dados_valid is 1 for the following cycle.
REQ-023 dados_valid shall be 0 in every cycle not immediately following an accepted read.
REQ-024 dados_out shall hold its last read value when no read is accepted; it is never high-impedance.
REQ-025 A read accepted in the cycle after a write to the same address shall return the newly written data.
REQ-026 Back-to-back reads shall each be accepted. dados_valid shall stay high across consecutive cycles, with dados_out updating every cycle.
REQ-027 enable=0 shall perform no access regardless of write_enable.
REQ-028 With BANK_BITS=0 the block shall behave as a single flat RAM with identical timing.

Reset
REQ-029 On a rising edge with rst=1, the block shall:
  - enter FILL with the counter at 0;
  - drive dados_out = 0, dados_valid = 0 and busy = 1 from the next cycle.
REQ-030 rst shall take priority over clear and over all requests.
REQ-031 rst asserted mid-FILL or mid-read shall discard the operation and restart the fill from word 0.
REQ-032 After rst deasserts, busy shall fall exactly 2^ADDR_W cycles later; with defaults, busy falls after 8 cycles.

Verification
REQ-033 The bench shall cover reset, then fill completion:
  - Stimulus: rst high 1 cycle, then low; hold enable=0.
  - Response: busy=1 for 8 cycles then 0; reading every address 0..7 returns 0x00.
REQ-034 The bench shall cover a write followed by a read:
  - Stimulus: in READY, write 0xA5 to addr 5, then read addr 5 on the next cycle.
  - Response: one cycle later dados_out=0xA5 with dados_valid=1.
REQ-035 The bench shall cover bank isolation:
  - Stimulus: write 0x11 to addr 1 and 0x22 to addr 5, then read addr 1 then addr 5 back-to-back.
  - Response: dados_valid is high 2 consecutive cycles with dados_out 0x11 then 0x22.
REQ-036 The bench shall cover requests ignored during fill:
  - Stimulus: pulse clear, then write 0xFF to addr 3 during FILL.
  - Response: busy=1 for 8 cycles, dados_valid stays 0; a later read of addr 3 returns 0x00.
REQ-037 The bench shall cover reset mid-fill:
  - Stimulus: assert rst at fill cycle 4.
  - Response: the counter restarts and busy stays high for 8 more cycles.
REQ-038 The bench shall cover the parameter sweep:
  - Stimulus: instantiate DATA_W=16, ADDR_W=6, BANK_BITS=2; write 0xBEEF to addr 63, then read it.
  - Response: the read returns 0xBEEF; fill lasts 64 cycles.
